// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush controller for the five-stage core.
// Resolves load-use, ifetch miss, data-memory wait, redirect and halt
// hazards, and keeps saturating performance counters.
module hazard_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_rd,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_pcsrc,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic dreq;
  logic loaduse;
  logic redirect;

  assign dreq    = mem_dren | mem_dwen;
  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign loaduse = ex_memtoreg & (ex_rd != 5'd0) &
                   ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // Prioritised hazard resolution: enables, flushes and next state.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;

    if (RST) begin
      // Hold the whole pipeline while reset is asserted.
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
    end else if (state_q == HALT) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
    end else begin
      // RUN and DWAIT share one rule table; DWAIT only differs in that it
      // was entered by an outstanding data access.
      state_d = RUN;
      if (dreq && !dhit) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        state_d = DWAIT;
      end else if (mem_halt) begin
        // Only the halt itself retires; everything younger freezes.
        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0;
        state_d = HALT;
      end else if (mem_pcsrc) begin
        // Redirect wins over load-use and ifetch miss: the younger
        // instructions are squashed regardless.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        redirect    = 1'b1;
      end else if (loaduse) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  // Saturating performance counters; all freeze in HALT.
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != HALT) begin
      if (cycle_q != '1)              cycle_d = cycle_q + CNT_W'(1);
      if (!pc_en && stall_q != '1)    stall_d = stall_q + CNT_W'(1);
      if (redirect && flush_q != '1)  flush_d = flush_q + CNT_W'(1);
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    if (RST) begin
      state_q <= RUN;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign halted    = (state_q == HALT);
  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline stall/flush controller for the five-stage core; it is the consumer-side counterpart of the forwarding logic. It resolves the hazards that forwarding cannot: load-use, instruction-fetch miss, data-memory wait, taken branch/jump redirect and halt. Each cycle it drives the PC and pipeline-register enable/flush controls, holds a small state machine for memory wait and halt, and keeps saturating performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction cache returned the instruction this cycle
- dhit  in  1  data cache completed the MEM-stage access this cycle
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_memtoreg  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of EX instruction
- mem_dren, mem_dwen  in  1 each  MEM-stage load / store in progress
- mem_pcsrc  in  1  taken branch or jump resolved in MEM
- mem_halt  in  1  halt instruction in MEM
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (NOP, all control bits 0) when the matching enable is 1
- halted  out  1  core halted (registered)
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- States: RUN, DWAIT, HALT. The state register is the only control storage. All enable and flush outputs are combinational from the state plus the inputs.
- dreq = mem_dren | mem_dwen.
- loaduse = ex_memtoreg & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- In RUN and DWAIT, the first matching rule below applies. Unlisted enables are 1 and unlisted flushes are 0.
  1. dreq & !dhit: all five enables 0, all flushes 0. Next state is DWAIT.
  2. mem_halt: memwb_en=1 and all other enables 0, so the halt retires. Next state is HALT.
  3. mem_pcsrc: pc_en=1 (loads the target, even if ihit=0). ifid_flush, idex_flush and exmem_flush are all 1. flush_cnt increments.
  4. loaduse: pc_en=0, ifid_en=0, idex_flush=1. EX/MEM/WB advance.
  5. !ihit: pc_en=0, ifid_flush=1 (bubble into ID). The rest of the pipeline advances.
  6. Otherwise: normal advance.
- Next-state rules:
  - DWAIT goes to RUN on the cycle dhit=1. That cycle is evaluated by rules 2–6 with the MEM access complete.
  - RUN stays in RUN unless rule 1 or rule 2 fires.
- HALT: all enables 0, all flushes 0, halted=1. The block stays in HALT until RST.
- Counters (each saturates at 2^CNT_W−1; none wraps):
  - cycle_cnt increments every cycle not in HALT.
  - stall_cnt increments every non-HALT cycle with pc_en=0.
  - flush_cnt increments on each rule-3 cycle.
  - All three counters freeze in HALT.
- Register $0 never causes a load-use stall.
- A redirect outranks load-use and ifetch miss, because the younger instructions are flushed anyway.

## Timing
- Reset (RST=1, asynchronous): state=RUN, halted=0, all counters 0.
  - While RST is high, force all enables and flushes to 0.
  - Reset mid-DWAIT or in HALT returns to RUN with the counters cleared.
- Enable and flush outputs have zero-cycle latency from the inputs. State, halted and the counters update on the rising edge of CLK.
- Load-use inserts exactly one bubble: next cycle the load is in MEM and the forwarding path supplies the data.
- halted rises on the edge after rule 2 fires and is 1 from the following cycle on.
- dhit during a DWAIT cycle with mem_pcsrc=1 applies the redirect in that same cycle.
- A redirect requires that no data wait is pending (rule 1 outranks it). A store/branch collision therefore stalls first, then redirects.

## Test plan
- **Load-use:** ex_memtoreg=1, ex_rd=5, id_rs=5, ihit=1 for one cycle.
  - That cycle: pc_en=0, ifid_en=0, idex_flush=1.
  - stall_cnt=1 and flush_cnt=0 afterwards.
  - Repeat with ex_rd=0: no stall.
- **Data wait:** mem_dren=1 with dhit=0 for 3 cycles, then dhit=1.
  - 3 cycles with all enables 0 and state DWAIT.
  - The 4th cycle has all enables 1 and state returns to RUN.
  - stall_cnt=3.
- **Redirect beats load-use and ifetch miss:** mem_pcsrc=1, loaduse true, ihit=0.
  - pc_en=1 and all three flushes 1.
  - flush_cnt increments by 1.
- **Ifetch miss:** ihit=0 for 2 cycles, otherwise idle.
  - pc_en=0 and ifid_flush=1 for both cycles.
  - idex_en, exmem_en and memwb_en stay 1.
- **Halt:** mem_halt=1.
  - That cycle: only memwb_en=1.
  - halted=1 from the next cycle, all enables 0.
  - Counters frozen for 10 further cycles.
  - RST pulse clears halted and the counters asynchronously.
- **Saturation:** CNT_W=4, run 20 unstalled cycles; cycle_cnt holds at 15.
